// File: rtl/palette_pkg.sv
// Shared types and reset contents for the colour-cycling palette.
package palette_pkg;

    localparam int PAL_CH_W = 4;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SHIFT
    } cyc_state_t;

    // Red ramp: every entry is full red, no green, blue equal to the entry number.
    localparam rgb_t [0:15] DEFAULT_PALETTE = {
        12'hF00, 12'hF01, 12'hF02, 12'hF03,
        12'hF04, 12'hF05, 12'hF06, 12'hF07,
        12'hF08, 12'hF09, 12'hF0A, 12'hF0B,
        12'hF0C, 12'hF0D, 12'hF0E, 12'hF0F
    };

endpackage

// File: rtl/palette_frame_div.sv
// Frame-tick divider: emits a one-cycle step every FRAMES_PER_STEP ticks while run is high.
module palette_frame_div
    import palette_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic frame_tick,
    output logic step
);

    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_STEP - 1);

    logic [CNT_W-1:0] count;

    assign step = run && frame_tick && (count == LAST);

    // Counter wraps even when the step is not used, so a degenerate range keeps cadence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (frame_tick) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/palette_cycle_ctrl.sv
// 16-entry RGB palette with host writes, periodic range rotation and registered lookup.
module palette_cycle_ctrl
    import palette_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 4,
    parameter int IDX_W           = 4,
    parameter int CH_W            = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [3*CH_W-1:0]  cfg_data,
    input  logic               cyc_en,
    input  logic [IDX_W-1:0]   cyc_lo,
    input  logic [IDX_W-1:0]   cyc_hi,
    input  logic               pix_valid,
    input  logic [IDX_W-1:0]   pix_index,
    output logic               out_valid,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue,
    output logic               busy
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int RGB_W = 3 * CH_W;

    logic [RGB_W-1:0] pal [DEPTH];

    cyc_state_t       state;
    logic [IDX_W-1:0] lo_q;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_dn;
    logic [RGB_W-1:0] temp;
    logic [RGB_W-1:0] pix_rgb;
    logic             wr_acc;
    logic             step;

    assign cfg_ready = (state != SHIFT);
    assign wr_acc    = cfg_valid && cfg_ready;
    assign ptr_dn    = ptr - IDX_W'(1);

    assign red   = pix_rgb[3*CH_W-1:2*CH_W];
    assign green = pix_rgb[2*CH_W-1:CH_W];
    assign blue  = pix_rgb[CH_W-1:0];

    palette_frame_div #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .run        ((state == COUNT) && cyc_en),
        .frame_tick (frame_tick),
        .step       (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            lo_q  <= '0;
            ptr   <= '0;
            temp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cyc_en) state <= COUNT;
                end
                COUNT: begin
                    if (!cyc_en) begin
                        state <= IDLE;
                    end else if (step && (cyc_lo < cyc_hi)) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        lo_q  <= cyc_lo;
                        ptr   <= cyc_hi;
                        // A same-cycle write to the top entry must be the value that wraps.
                        temp  <= (wr_acc && (cfg_addr == cyc_hi)) ? cfg_data : pal[cyc_hi];
                    end
                end
                SHIFT: begin
                    if (ptr > lo_q) begin
                        ptr <= ptr_dn;
                    end else begin
                        busy  <= 1'b0;
                        state <= cyc_en ? COUNT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Host writes are blocked during SHIFT, so the two update paths never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pal[i] <= RGB_W'(DEFAULT_PALETTE[i[3:0]]);
        end else begin
            if (wr_acc) pal[cfg_addr] <= cfg_data;
            if (state == SHIFT) begin
                if (ptr > lo_q) pal[ptr]  <= pal[ptr_dn];
                else            pal[lo_q] <= temp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            pix_rgb   <= '0;
        end else begin
            out_valid <= pix_valid;
            if (pix_valid) pix_rgb <= pal[pix_index];
        end
    end

endmodule
